// File: rtl/mem_dp_resp_pkg.sv
// Shared sizes and state encoding for the stage-5 data-memory responder.
package mem_dp_resp_pkg;

  localparam int unsigned SIZE_ADDR      = 24;
  localparam int unsigned SIZE_DATA      = 24;
  localparam int unsigned MEM_DEPTH_LOG2 = 10;

  typedef enum logic {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_RUN   = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_array_2w2r.sv
// Storage array with two write ports and two asynchronous read ports.
// When both ports write the same word, port 0's data is kept.
module mem_array_2w2r #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WIDTH      = 24
) (
  input  logic                  iw_clk,
  input  logic                  iw_we    [0:1],
  input  logic [DEPTH_LOG2-1:0] iw_widx  [0:1],
  input  logic [WIDTH-1:0]      iw_wdata [0:1],
  input  logic [DEPTH_LOG2-1:0] iw_ridx  [0:1],
  output logic [WIDTH-1:0]      ow_rdata [0:1]
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Port 0 is applied last so it overrides port 1 on a shared index.
  always_ff @(posedge iw_clk) begin
    if (iw_we[1]) r_mem[iw_widx[1]] <= iw_wdata[1];
    if (iw_we[0]) r_mem[iw_widx[0]] <= iw_wdata[0];
  end

  assign ow_rdata[0] = r_mem[iw_ridx[0]];
  assign ow_rdata[1] = r_mem[iw_ridx[1]];

endmodule

// File: rtl/mem_dp_resp.sv
// Dual-port data-memory responder: zero-fill after reset, then write-first
// reads with one-cycle latency and port-0 priority on write collisions.
module mem_dp_resp
  import mem_dp_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2,
  parameter bit          CLR_EN     = 1'b1
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_re     [0:1],
  input  logic                 iw_we     [0:1],
  input  logic [SIZE_ADDR-1:0] iw_addr   [0:1],
  input  logic [SIZE_DATA-1:0] iw_wdata  [0:1],
  output logic [SIZE_DATA-1:0] ow_rdata  [0:1],
  output logic                 ow_rvalid [0:1],
  output logic                 ow_ready,
  output logic                 ow_wcoll
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  mem_state_e            r_state;
  logic [DEPTH_LOG2-1:0] r_clr_idx;

  logic                  run;
  logic                  coll;
  logic [DEPTH_LOG2-1:0] idx       [0:1];
  logic                  arr_we    [0:1];
  logic [DEPTH_LOG2-1:0] arr_widx  [0:1];
  logic [SIZE_DATA-1:0]  arr_wdata [0:1];
  logic [SIZE_DATA-1:0]  arr_rdata [0:1];
  logic [SIZE_DATA-1:0]  fwd_data  [0:1];

  // Upper address bits are intentionally dropped so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{iw_addr[0][SIZE_ADDR-1:DEPTH_LOG2],
                            iw_addr[1][SIZE_ADDR-1:DEPTH_LOG2]};

  assign run    = (r_state == MEM_ST_RUN);
  assign idx[0] = iw_addr[0][DEPTH_LOG2-1:0];
  assign idx[1] = iw_addr[1][DEPTH_LOG2-1:0];
  assign coll   = run && iw_we[0] && iw_we[1] && (idx[0] == idx[1]);

  always_comb begin
    arr_we[0]    = 1'b0;
    arr_we[1]    = 1'b0;
    arr_widx[0]  = idx[0];
    arr_widx[1]  = idx[1];
    arr_wdata[0] = iw_wdata[0];
    arr_wdata[1] = iw_wdata[1];
    if (run) begin
      arr_we[0] = iw_we[0];
      arr_we[1] = iw_we[1] && !coll;
    end else begin
      arr_we[0]    = CLR_EN;
      arr_widx[0]  = r_clr_idx;
      arr_wdata[0] = '0;
    end
  end

  // Write-first forwarding; port 0 is checked last so it wins a collision.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_data[p] = arr_rdata[p];
      if (iw_we[1] && (idx[1] == idx[p])) fwd_data[p] = iw_wdata[1];
      if (iw_we[0] && (idx[0] == idx[p])) fwd_data[p] = iw_wdata[0];
    end
  end

  mem_array_2w2r #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SIZE_DATA)
  ) u_array (
    .iw_clk   (iw_clk),
    .iw_we    (arr_we),
    .iw_widx  (arr_widx),
    .iw_wdata (arr_wdata),
    .iw_ridx  (idx),
    .ow_rdata (arr_rdata)
  );

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state      <= MEM_ST_CLEAR;
      r_clr_idx    <= '0;
      ow_ready     <= 1'b0;
      ow_wcoll     <= 1'b0;
      ow_rdata[0]  <= '0;
      ow_rdata[1]  <= '0;
      ow_rvalid[0] <= 1'b0;
      ow_rvalid[1] <= 1'b0;
    end else begin
      case (r_state)
        MEM_ST_CLEAR: begin
          ow_wcoll     <= 1'b0;
          ow_rdata[0]  <= '0;
          ow_rdata[1]  <= '0;
          ow_rvalid[0] <= 1'b0;
          ow_rvalid[1] <= 1'b0;
          if (!CLR_EN) begin
            r_state  <= MEM_ST_RUN;
            ow_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == LAST_IDX) begin
              r_state  <= MEM_ST_RUN;
              ow_ready <= 1'b1;
            end
          end
        end
        MEM_ST_RUN: begin
          ow_ready <= 1'b1;
          ow_wcoll <= coll;
          for (int p = 0; p < 2; p++) begin
            ow_rvalid[p] <= iw_re[p];
            if (iw_re[p]) ow_rdata[p] <= fwd_data[p];
          end
        end
        default: begin
          r_state  <= MEM_ST_CLEAR;
          ow_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dp_resp.sv
// Randomized self-checking bench for mem_dp_resp against an array-level model.
module tb_mem_dp_resp;
  import mem_dp_resp_pkg::*;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 1 << DL;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 re     [0:1];
  logic                 we     [0:1];
  logic [SIZE_ADDR-1:0] addr   [0:1];
  logic [SIZE_DATA-1:0] wdata  [0:1];
  logic [SIZE_DATA-1:0] rdata  [0:1];
  logic                 rvalid [0:1];
  logic                 ready;
  logic                 wcoll;

  int n_cmp = 0;
  int n_err = 0;

  logic [SIZE_DATA-1:0] model  [DEPTH];
  logic [SIZE_DATA-1:0] exp_rd [0:1];

  always #5 clk = ~clk;

  mem_dp_resp #(
    .DEPTH_LOG2 (DL),
    .CLR_EN     (1'b1)
  ) dut (
    .iw_clk    (clk),
    .iw_rst_n  (rst_n),
    .iw_re     (re),
    .iw_we     (we),
    .iw_addr   (addr),
    .iw_wdata  (wdata),
    .ow_rdata  (rdata),
    .ow_rvalid (rvalid),
    .ow_ready  (ready),
    .ow_wcoll  (wcoll)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [SIZE_ADDR-1:0] a0,
                       input logic [SIZE_DATA-1:0] d0, input logic r1, input logic w1,
                       input logic [SIZE_ADDR-1:0] a1, input logic [SIZE_DATA-1:0] d1);
    re[0] = r0; we[0] = w0; addr[0] = a0; wdata[0] = d0;
    re[1] = r1; we[1] = w1; addr[1] = a1; wdata[1] = d1;
  endtask

  task automatic drive_random();
    logic [SIZE_ADDR-1:0] a [0:1];
    for (int p = 0; p < 2; p++) begin
      a[p] = SIZE_ADDR'($urandom());
      if ($urandom_range(0, 1) == 1) a[p][DL-1:0] = DL'($urandom_range(0, 3));
    end
    drive(1'($urandom()), 1'($urandom()), a[0], SIZE_DATA'($urandom()),
          1'($urandom()), 1'($urandom()), a[1], SIZE_DATA'($urandom()));
  endtask

  // One RUN-state request: the array is updated write-first (port 0 last, so
  // it wins), reads then see the updated array.
  task automatic step(input logic r0, input logic w0, input logic [SIZE_ADDR-1:0] a0,
                      input logic [SIZE_DATA-1:0] d0, input logic r1, input logic w1,
                      input logic [SIZE_ADDR-1:0] a1, input logic [SIZE_DATA-1:0] d1);
    int i0, i1;
    logic e_coll;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    i0 = int'(a0 % DEPTH);
    i1 = int'(a1 % DEPTH);
    if (w1) model[i1] = d1;
    if (w0) model[i0] = d0;
    e_coll = w0 && w1 && (i0 == i1);
    if (r0) exp_rd[0] = model[i0];
    if (r1) exp_rd[1] = model[i1];
    @(posedge clk); #1;
    check("rdata0", 32'(rdata[0]), 32'(exp_rd[0]));
    check("rdata1", 32'(rdata[1]), 32'(exp_rd[1]));
    check("rvalid0", 32'(rvalid[0]), 32'(r0));
    check("rvalid1", 32'(rvalid[1]), 32'(r1));
    check("wcoll", 32'(wcoll), 32'(e_coll));
    check("ready_run", 32'(ready), 32'd1);
  endtask

  // Random traffic during the clear must be dropped; count edges until ready.
  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 3 * DEPTH) begin
      drive_random();
      @(posedge clk); #1;
      cnt++;
      check("clr_rvalid0", 32'(rvalid[0]), 32'd0);
      check("clr_rvalid1", 32'(rvalid[1]), 32'd0);
      check("clr_rdata0", 32'(rdata[0]), 32'd0);
    end
    check(tag, cnt, DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    #23;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid0", 32'(rvalid[0]), 32'd0);
    check("rst_wcoll", 32'(wcoll), 32'd0);
    rst_n = 1'b1;
    wait_clear("clear_cycles");

    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, SIZE_ADDR'(i), '0, 1'b1, 1'b0, SIZE_ADDR'(DEPTH - 1 - i), '0);

    // Basic write then cross-port read.
    step(1'b0, 1'b1, 24'd5, 24'h00ABCD, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 24'd5, '0);
    check("basic_rd", 32'(rdata[1]), 32'h00ABCD);
    // Cross-port forwarding.
    step(1'b1, 1'b0, 24'd9, '0, 1'b0, 1'b1, 24'd9, 24'h000077);
    check("fwd_rd", 32'(rdata[0]), 32'h000077);
    // Same-port forwarding.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 24'd12, 24'h0000C3);
    check("self_fwd", 32'(rdata[1]), 32'h0000C3);
    // Write collision with a same-cycle read on port 1.
    step(1'b0, 1'b1, 24'd3, 24'h000011, 1'b1, 1'b1, 24'd3, 24'h000022);
    check("coll_pulse", 32'(wcoll), 32'd1);
    check("coll_rd", 32'(rdata[1]), 32'h000011);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    check("coll_drop", 32'(wcoll), 32'd0);
    step(1'b1, 1'b0, 24'd3, '0, 1'b0, 1'b0, '0, '0);
    check("coll_later", 32'(rdata[0]), 32'h000011);
    // Address wrap, including high address bits.
    step(1'b0, 1'b1, SIZE_ADDR'(DEPTH + 2), 24'h0000BE, 1'b0, 1'b1, 24'hFFFF07, 24'h0000EF);
    step(1'b1, 1'b0, 24'd7, '0, 1'b1, 1'b0, 24'd2, '0);
    check("wrap_rd2", 32'(rdata[1]), 32'h0000BE);
    check("wrap_rd7", 32'(rdata[0]), 32'h0000EF);
    // Idle cycle: rvalid drops, rdata holds.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

    // Reset mid-clear at clear index 7.
    rst_n = 1'b0;
    #2;
    check("rst2_ready", 32'(ready), 32'd0);
    check("rst2_rdata1", 32'(rdata[1]), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_random();
      @(posedge clk); #1;
      check("partial_ready", 32'(ready), 32'd0);
    end
    rst_n = 1'b0;
    #2;
    check("midclr_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    wait_clear("clear_after_midreset");

    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, SIZE_ADDR'(i), '0, 1'b0, 1'b0, '0, '0);

    for (int n = 0; n < 400; n++) begin
      logic [SIZE_ADDR-1:0] a [0:1];
      for (int p = 0; p < 2; p++) begin
        a[p] = SIZE_ADDR'($urandom());
        if ($urandom_range(0, 1) == 1) a[p][DL-1:0] = DL'($urandom_range(0, 3));
      end
      step(1'($urandom()), 1'($urandom()), a[0], SIZE_DATA'($urandom()),
           1'($urandom()), 1'($urandom()), a[1], SIZE_DATA'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dp_resp.md
Name: mem_dp_resp

Overview:
- Dual-port data-memory responder at the far end of the stage-5 memory interface.
- Serves two independent ports. Each port takes an address, a write enable and write data, and returns read data one cycle after the request.
- After reset, zero-fills the whole array before accepting traffic.
- Provides write-first forwarding and a fixed arbitration rule when both ports address the same word in the same cycle.

Parameters:
DEPTH_LOG2, 10, log2 of words in the array; DEPTH = 2**DEPTH_LOG2.
CLR_EN, 1, 1 = zero-fill after reset; 0 = go straight to RUN (array contents undefined).

Ports:
iw_clk  in  1  clock.
iw_rst_n  in  1  asynchronous reset, active low.
iw_re [0:1]  in  1 each  read request, per port.
iw_we [0:1]  in  1 each  write request, per port.
iw_addr [0:1]  in  `SIZE_ADDR each  word address; only bits [DEPTH_LOG2-1:0] are used.
iw_wdata [0:1]  in  `SIZE_DATA each  write data.
ow_rdata [0:1]  out  `SIZE_DATA each  registered read data.
ow_rvalid [0:1]  out  1 each  high one cycle after an accepted iw_re.
ow_ready  out  1  high in RUN state only.
ow_wcoll  out  1  registered pulse: both ports wrote the same index in the previous cycle.

Behaviour:
- Reset (iw_rst_n = 0, asynchronous): all outputs 0, FSM = CLEAR, r_clr_idx = 0. Array contents are not reset by the flop reset.
- FSM states:
  - CLEAR: each cycle writes 0 to index r_clr_idx and increments it. When r_clr_idx = DEPTH-1, the write completes and the FSM goes to RUN on the next edge. This takes exactly DEPTH cycles.
  - RUN: ow_ready = 1. The FSM stays in RUN until reset.
  - CLR_EN = 0: after reset the FSM enters RUN on the first clock edge.
- Reset asserted mid-CLEAR: restart from index 0 after release.
- Not ready (CLEAR): iw_re and iw_we are ignored, ow_rvalid = 0, ow_rdata = 0. Requests are dropped, not queued.
- Index: idx[p] = iw_addr[p][DEPTH_LOG2-1:0]; upper bits are silently ignored, so addresses wrap.
- Write: takes effect at the clock edge of the request cycle.
- Read latency: ow_rdata[p] and ow_rvalid[p] update at the edge after iw_re[p] and hold until the next accepted read. ow_rvalid drops to 0 in cycles without a read; ow_rdata holds its value.
- Forwarding, write-first:
  - Same port, iw_re and iw_we at the same idx: the read returns iw_wdata.
  - Port a reads idx while port b writes idx in the same cycle: port a returns port b's iw_wdata.
- Write collision: both ports write the same idx in the same cycle.
  - Port 0 wins; port 1's write is discarded.
  - ow_wcoll pulses for one cycle.
  - Any read of that idx in that cycle returns port 0's data.
- Independent indices: both ports read and write fully in parallel, with no stalls ever.
- No backpressure: a new request is accepted every cycle in RUN.

Decomposition:
- Add `MEM_DEPTH_LOG2 (default 10) to src/sizes.vh; reuse the existing `SIZE_ADDR and `SIZE_DATA.
- Add FSM state encodings `MEM_ST_CLEAR = 1'b0 and `MEM_ST_RUN = 1'b1 to a new src/mem.vh.
- One sub-module, mem_array_2w2r: a DEPTH x `SIZE_DATA storage array with two write ports and two asynchronous read ports, where port 0 has write priority.
- mem_dp_resp contains the clear FSM, forwarding/collision logic and the output registers.

Test Plan:
- Clear after reset: release iw_rst_n with DEPTH_LOG2 = 4 -> ow_ready rises exactly 16 cycles later. Then reading every index 0..15 -> ow_rdata = 0 with ow_rvalid = 1 one cycle after each read.
- Basic write/read: port 0 writes 0x00ABCD at addr 5; next cycle port 1 reads addr 5 -> ow_rdata[1] = 0x00ABCD one cycle later.
- Forwarding: same cycle, port 1 writes 0x000077 at addr 9 and port 0 reads addr 9 -> ow_rdata[0] = 0x000077 on the next edge.
- Write collision: both ports write addr 3 (port 0 = 0x000011, port 1 = 0x000022) -> ow_wcoll = 1 for one cycle; a later read of addr 3 returns 0x000011.
- Wrap and drop:
  - A write to addr DEPTH+2 is readable at addr 2.
  - A write issued while ow_ready = 0 is lost: the location reads 0 after the clear.
- Reset mid-clear: assert iw_rst_n = 0 at clear index 7, release -> ow_ready rises DEPTH cycles after the release, not earlier.
